pipe_os_gen: RTL and testbench

- Parametrised, multi-lane ordered-set generator that drives the PIPE RX-side symbol interface (rxdata/rxdatak/rxvalid) of the PHY model.
- Emits logical idle, SKP, TS1 or TS2 ordered sets, with per-lane lane numbering, proper K-flags, bounded TS bursts and periodic SKP insertion.
- Sits between the LTSSM-facing stimulus/control logic and the PHY receive path.

---
 rtl/pipe_os_gen_if.sv | 14 +
 rtl/pipe_os_gen.sv | 183 ++++++++++++++++++
 tb/tb_pipe_os_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_os_gen_if.sv
// PIPE RX-side symbol bus and OS framing strobes driven by pipe_os_gen.
interface pipe_os_gen_if #(
  parameter int LANES = 1
);
  logic [LANES*8-1:0] rxdata;
  logic [LANES-1:0]   rxdatak;
  logic               rxvalid;
  logic               os_start;
  logic               os_done;
  logic               busy;

  modport master (output rxdata, rxdatak, rxvalid, os_start, os_done, busy);
  modport slave  (input  rxdata, rxdatak, rxvalid, os_start, os_done, busy);
endinterface

// File: rtl/pipe_os_gen.sv
// Multi-lane ordered-set generator (idle, SKP, TS1, TS2) feeding the PIPE RX symbol path.
// Outputs always show the symbol selected at the previous edge; the OS choice is made on boundary cycles.
module pipe_os_gen #(
  parameter int LANES        = 1,
  parameter int SKP_LEN      = 4,
  parameter int SKP_INTERVAL = 1180
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_n,
  input  logic [1:0]    mode,
  input  logic [39:0]   ts_fields,
  input  logic          lane_pad,
  input  logic [7:0]    os_count,
  input  logic          skp_en,
  pipe_os_gen_if.master rx
);

  localparam logic [7:0] SYM_COM   = 8'hBC;
  localparam logic [7:0] SYM_SKP   = 8'h1C;
  localparam logic [7:0] SYM_PAD   = 8'hF7;
  localparam logic [7:0] SYM_TS1ID = 8'h4A;
  localparam logic [7:0] SYM_TS2ID = 8'h45;
  localparam int         TW        = $clog2(SKP_INTERVAL);
  localparam logic [3:0]    SKP_LAST   = 4'(SKP_LEN - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SKP_INTERVAL - 1);
  localparam logic [TW-1:0] TIMER_ARM  = TW'(SKP_INTERVAL - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_SKP, ST_TS} state_t;

  state_t          state, state_nx;
  logic [3:0]      sym, sym_nx;
  logic            ts2, ts2_nx;
  logic [39:0]     fields, fields_nx;
  logic            pad, pad_nx;
  logic [1:0]      mode_prev, mode_prev_nx;
  logic [7:0]      burst, burst_nx;
  logic [TW-1:0]   timer;
  logic            skp_pending;
  logic            boundary, mode_changed, exhausted;
  logic            start_skp, start_ts, done_nx;
  logic [LANES*8-1:0] data_nx;
  logic [LANES-1:0]   k_nx;

  always_comb begin
    boundary     = (state == ST_IDLE) ||
                   (state == ST_SKP && sym == SKP_LAST) ||
                   (state == ST_TS  && sym == 4'd15);
    mode_changed = (mode != mode_prev);
    exhausted    = (os_count != 8'd0) && (burst >= os_count);
    state_nx     = state;
    sym_nx       = sym + 4'd1;
    ts2_nx       = ts2;
    fields_nx    = fields;
    pad_nx       = pad;
    mode_prev_nx = mode_prev;
    burst_nx     = burst;
    start_skp    = 1'b0;
    start_ts     = 1'b0;
    done_nx      = 1'b0;
    if (boundary) begin
      mode_prev_nx = mode;
      sym_nx       = 4'd0;
      if (mode_changed) burst_nx = 8'd0;
      if (skp_pending)                     start_skp = 1'b1;
      else if (exhausted && !mode_changed) start_skp = 1'b0;
      else if (mode == 2'd1)               start_skp = 1'b1;
      else if (mode[1])                    start_ts  = 1'b1;
      state_nx = start_skp ? ST_SKP : (start_ts ? ST_TS : ST_IDLE);
      if (start_ts) begin
        ts2_nx    = mode[0];
        fields_nx = ts_fields;
        pad_nx    = lane_pad;
      end
    end else if (state == ST_TS && sym == 4'd14) begin
      // The count advances as the last TS symbol goes out, so os_done lines up with it.
      if (burst != 8'hFF) burst_nx = burst + 8'd1;
      done_nx = (os_count != 8'd0) && (burst + 8'd1 == os_count);
    end
  end

  always_comb begin
    data_nx = '0;
    k_nx    = '0;
    for (int i = 0; i < LANES; i++) begin
      case (state_nx)
        ST_SKP: begin
          data_nx[8*i +: 8] = (sym_nx == 4'd0) ? SYM_COM : SYM_SKP;
          k_nx[i]           = 1'b1;
        end
        ST_TS: begin
          case (sym_nx)
            4'd0: begin
              data_nx[8*i +: 8] = SYM_COM;
              k_nx[i]           = 1'b1;
            end
            4'd1: begin
              data_nx[8*i +: 8] = pad_nx ? SYM_PAD : fields_nx[7:0];
              k_nx[i]           = pad_nx;
            end
            4'd2: begin
              data_nx[8*i +: 8] = pad_nx ? SYM_PAD : fields_nx[15:8] + 8'(i);
              k_nx[i]           = pad_nx;
            end
            4'd3:    data_nx[8*i +: 8] = fields_nx[23:16];
            4'd4:    data_nx[8*i +: 8] = fields_nx[31:24];
            4'd5:    data_nx[8*i +: 8] = fields_nx[39:32];
            default: data_nx[8*i +: 8] = ts2_nx ? SYM_TS2ID : SYM_TS1ID;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sym       <= '0;
      ts2       <= 1'b0;
      fields    <= '0;
      pad       <= 1'b0;
      mode_prev <= '0;
      burst     <= '0;
    end else if (en_n) begin
      state     <= ST_IDLE;
      sym       <= '0;
      ts2       <= 1'b0;
      fields    <= '0;
      pad       <= 1'b0;
      mode_prev <= '0;
      burst     <= '0;
    end else begin
      state     <= state_nx;
      sym       <= sym_nx;
      ts2       <= ts2_nx;
      fields    <= fields_nx;
      pad       <= pad_nx;
      mode_prev <= mode_prev_nx;
      burst     <= burst_nx;
    end
  end

  // Pending rises on the edge the timer reaches its last value, then both hold until a SKP starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      skp_pending <= 1'b0;
    end else if (en_n || !skp_en || start_skp) begin
      timer       <= '0;
      skp_pending <= 1'b0;
    end else if (timer != TIMER_LAST) begin
      timer <= timer + 1'b1;
      if (timer == TIMER_ARM) skp_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.rxdata   <= '0;
      rx.rxdatak  <= '0;
      rx.rxvalid  <= 1'b0;
      rx.os_start <= 1'b0;
      rx.os_done  <= 1'b0;
      rx.busy     <= 1'b0;
    end else if (en_n) begin
      rx.rxdata   <= '0;
      rx.rxdatak  <= '0;
      rx.rxvalid  <= 1'b0;
      rx.os_start <= 1'b0;
      rx.os_done  <= 1'b0;
      rx.busy     <= 1'b0;
    end else begin
      rx.rxdata   <= data_nx;
      rx.rxdatak  <= k_nx;
      rx.rxvalid  <= 1'b1;
      rx.os_start <= start_skp | start_ts;
      rx.os_done  <= done_nx;
      rx.busy     <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pipe_os_gen.sv
// Bench for pipe_os_gen: per-cycle queue-based reference model, a vector table and
// hand-written multi-cycle sequences, followed by randomized traffic.
module tb_pipe_os_gen;
  localparam int LANES   = 4;
  localparam int SKP_LEN = 4;
  localparam int SI      = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_n = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [39:0] ts_fields = '0;
  logic        lane_pad = 1'b0;
  logic [7:0]  os_count = 8'd0;
  logic        skp_en = 1'b0;
  int          checks = 0;
  int          fails = 0;

  pipe_os_gen_if #(.LANES(LANES)) bus ();

  pipe_os_gen #(.LANES(LANES), .SKP_LEN(SKP_LEN), .SKP_INTERVAL(SI)) dut (
    .clk(clk), .reset_n(reset_n), .en_n(en_n), .mode(mode), .ts_fields(ts_fields),
    .lane_pad(lane_pad), .os_count(os_count), .skp_en(skp_en), .rx(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*8-1:0] data;
    logic [LANES-1:0]   k;
    logic               valid;
    logic               start;
    logic               done;
    logic               busy;
  } sym_t;

  // Model: whole ordered sets are queued at a boundary and popped one symbol per cycle.
  sym_t       q[$];
  sym_t       exp_s = '0;
  int         age = 0;
  logic [1:0] last_mode = 2'd0;
  int         bursts = 0;

  task automatic push_idle();
    sym_t r;
    r = '0;
    r.valid = 1'b1;
    q.push_back(r);
  endtask

  task automatic push_skp();
    for (int s = 0; s < SKP_LEN; s++) begin
      sym_t r;
      r = '0;
      r.valid = 1'b1;
      r.busy  = 1'b1;
      r.start = (s == 0);
      r.k     = '1;
      for (int l = 0; l < LANES; l++) r.data[l*8 +: 8] = (s == 0) ? 8'hBC : 8'h1C;
      q.push_back(r);
    end
  endtask

  task automatic push_ts();
    logic [7:0] f [1:5];
    for (int j = 1; j <= 5; j++) f[j] = ts_fields[8*(j-1) +: 8];
    for (int s = 0; s < 16; s++) begin
      sym_t r;
      r = '0;
      r.valid = 1'b1;
      r.busy  = 1'b1;
      r.start = (s == 0);
      r.done  = (s == 15) && (os_count != 8'd0) && (bursts + 1 == int'(os_count));
      for (int l = 0; l < LANES; l++) begin
        logic [7:0] d;
        logic       kk;
        if (s == 0) begin
          d = 8'hBC; kk = 1'b1;
        end else if ((s == 1 || s == 2) && lane_pad) begin
          d = 8'hF7; kk = 1'b1;
        end else if (s <= 5) begin
          d = (s == 2) ? 8'((int'(f[2]) + l) % 256) : f[s];
          kk = 1'b0;
        end else begin
          d = mode[0] ? 8'h45 : 8'h4A; kk = 1'b0;
        end
        r.data[l*8 +: 8] = d;
        r.k[l] = kk;
      end
      q.push_back(r);
    end
    bursts++;
  endtask

  task automatic model_edge();
    bit skp_start;
    bit changed;
    if (!reset_n || en_n) begin
      q.delete();
      age = 0;
      last_mode = 2'd0;
      bursts = 0;
      exp_s = '0;
      return;
    end
    skp_start = 1'b0;
    if (q.size() == 0) begin
      changed = (mode != last_mode);
      last_mode = mode;
      if (changed) bursts = 0;
      if (age >= SI - 1) begin
        push_skp(); skp_start = 1'b1;
      end else if (os_count != 8'd0 && bursts >= int'(os_count) && !changed) begin
        push_idle();
      end else if (mode == 2'd1) begin
        push_skp(); skp_start = 1'b1;
      end else if (mode >= 2'd2) begin
        push_ts();
      end else begin
        push_idle();
      end
    end
    exp_s = q.pop_front();
    if (skp_start || !skp_en) age = 0;
    else if (age < SI - 1) age++;
  endtask

  task automatic check_model();
    checks++;
    if (bus.rxdata !== exp_s.data || bus.rxdatak !== exp_s.k || bus.rxvalid !== exp_s.valid ||
        bus.os_start !== exp_s.start || bus.os_done !== exp_s.done || bus.busy !== exp_s.busy) begin
      fails++;
      $display("[TB] FAIL model t=%0t got data=%h k=%b v=%b st=%b dn=%b bz=%b exp data=%h k=%b v=%b st=%b dn=%b bz=%b",
               $time, bus.rxdata, bus.rxdatak, bus.rxvalid, bus.os_start, bus.os_done, bus.busy,
               exp_s.data, exp_s.k, exp_s.valid, exp_s.start, exp_s.done, exp_s.busy);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic restart();
    en_n = 1'b1;
    step();
    en_n = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic p, input logic [39:0] f,
                                input logic [7:0] cnt, input logic se);
    mode = m;
    lane_pad = p;
    ts_fields = f;
    os_count = cnt;
    skp_en = se;
  endtask

  task automatic wait_start(input int max_cycles);
    int n;
    n = 0;
    while (bus.os_start !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check_output("os_start_seen", 32'(bus.os_start), 32'd1);
  endtask

  function automatic logic [39:0] fields_with(input logic [7:0] base);
    return {8'h44, 8'h33, 8'h22, base, 8'h11};
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic       pad;
    logic [7:0] base;
    int         sym;
    int         lane;
    logic [7:0] exp_data;
    logic       exp_k;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int starts, done_at, busy_n, prev, nskp, maxgap, bad;
    logic [7:0] d0 [300];
    logic       st [300];
    logic [3:0] kk [300];

    vecs.push_back('{2'd2, 1'b0, 8'h05, 0,  0, 8'hBC, 1'b1});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 1,  2, 8'h11, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 2,  0, 8'h05, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 2,  3, 8'h08, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'hFE, 2,  3, 8'h01, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 3,  1, 8'h22, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 4,  2, 8'h33, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 5,  3, 8'h44, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 6,  0, 8'h4A, 1'b0});
    vecs.push_back('{2'd2, 1'b0, 8'h05, 15, 3, 8'h4A, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 8'h05, 10, 2, 8'h45, 1'b0});
    vecs.push_back('{2'd3, 1'b1, 8'h05, 1,  1, 8'hF7, 1'b1});
    vecs.push_back('{2'd3, 1'b1, 8'h05, 2,  3, 8'hF7, 1'b1});
    vecs.push_back('{2'd3, 1'b1, 8'h05, 3,  0, 8'h22, 1'b0});
    vecs.push_back('{2'd1, 1'b0, 8'h05, 0,  1, 8'hBC, 1'b1});
    vecs.push_back('{2'd1, 1'b0, 8'h05, 3,  2, 8'h1C, 1'b1});
    vecs.push_back('{2'd2, 1'b1, 8'h05, 2,  0, 8'hF7, 1'b1});

    step();
    check_output("reset_rxvalid", 32'(bus.rxvalid), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;

    apply_stimulus(2'd0, 1'b0, '0, 8'd0, 1'b0);
    en_n = 1'b0;
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.os_start) starts++;
    end
    check_output("idle_os_start_count", 32'(starts), 32'd0);
    check_output("idle_rxvalid", 32'(bus.rxvalid), 32'd1);
    check_output("idle_rxdata", bus.rxdata, 32'd0);

    foreach (vecs[v]) begin
      restart();
      apply_stimulus(vecs[v].mode, vecs[v].pad, fields_with(vecs[v].base), 8'd0, 1'b0);
      wait_start(4);
      for (int s = 0; s < vecs[v].sym; s++) step();
      check_output($sformatf("vec%0d_data", v), 32'(bus.rxdata[vecs[v].lane*8 +: 8]), 32'(vecs[v].exp_data));
      check_output($sformatf("vec%0d_k", v), 32'(bus.rxdatak[vecs[v].lane]), 32'(vecs[v].exp_k));
    end

    restart();
    apply_stimulus(2'd2, 1'b0, fields_with(8'h05), 8'd2, 1'b0);
    starts = 0; done_at = -1; busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.os_start) starts++;
      if (bus.os_done) done_at = c;
      if (bus.busy) busy_n++;
      if (c == 33) begin
        check_output("burst_idle_busy", 32'(bus.busy), 32'd0);
        check_output("burst_idle_data", bus.rxdata, 32'd0);
      end
    end
    check_output("burst_os_count", 32'(starts), 32'd2);
    check_output("burst_done_cycle", 32'(done_at), 32'd32);
    check_output("burst_busy_cycles", 32'(busy_n), 32'd32);

    restart();
    apply_stimulus(2'd2, 1'b0, fields_with(8'h05), 8'd0, 1'b0);
    wait_start(4);
    repeat (7) step();
    check_output("switch_sym7", 32'(bus.rxdata[7:0]), 32'h4A);
    mode = 2'd3;
    repeat (8) step();
    check_output("switch_sym15", 32'(bus.rxdata[7:0]), 32'h4A);
    step();
    check_output("switch_next_start", 32'(bus.os_start), 32'd1);
    check_output("switch_next_com", 32'(bus.rxdata[7:0]), 32'hBC);
    repeat (6) step();
    check_output("switch_ts2id", 32'(bus.rxdata[7:0]), 32'h45);

    restart();
    apply_stimulus(2'd2, 1'b0, fields_with(8'h05), 8'd0, 1'b1);
    for (int c = 0; c < 300; c++) begin
      step();
      d0[c] = bus.rxdata[7:0];
      st[c] = bus.os_start;
      kk[c] = bus.rxdatak;
    end
    prev = -1; nskp = 0; maxgap = 0; bad = 0;
    for (int c = 1; c < 297; c++) begin
      if (st[c] && d0[c] == 8'hBC && d0[c+1] == 8'h1C) begin
        nskp++;
        if (d0[c+2] != 8'h1C || d0[c+3] != 8'h1C || kk[c] != 4'hF || kk[c+1] != 4'hF ||
            kk[c+2] != 4'hF || kk[c+3] != 4'hF) bad++;
        if (d0[c-1] != 8'h4A) bad++;
        if (prev >= 0 && c - prev > maxgap) maxgap = c - prev;
        prev = c;
      end
    end
    check_output("skp_count_min", 32'(nskp >= 4), 32'd1);
    check_output("skp_shape_and_boundary", 32'(bad), 32'd0);
    check_output("skp_gap_max", 32'(maxgap <= SI + 15), 32'd1);

    restart();
    apply_stimulus(2'd2, 1'b0, fields_with(8'h05), 8'd2, 1'b0);
    wait_start(4);
    repeat (25) step();
    check_output("rst_sym9", 32'(bus.rxdata[7:0]), 32'h4A);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_async_data", bus.rxdata, 32'd0);
    check_output("rst_async_valid", 32'(bus.rxvalid), 32'd0);
    check_output("rst_async_busy", 32'(bus.busy), 32'd0);
    step();
    reset_n = 1'b1;
    done_at = -1;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (c == 1) begin
        check_output("rst_fresh_start", 32'(bus.os_start), 32'd1);
        check_output("rst_fresh_com", 32'(bus.rxdata[7:0]), 32'hBC);
      end
      if (bus.os_done && done_at < 0) done_at = c;
    end
    check_output("rst_burst_restart", 32'(done_at), 32'd32);

    for (int seg = 0; seg < 6; seg++) begin
      restart();
      apply_stimulus(2'($urandom_range(0, 3)), 1'b0, {8'($urandom()), 32'($urandom())},
                     8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
        ts_fields = {8'($urandom()), 32'($urandom())};
        lane_pad = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 29) == 0) skp_en = ~skp_en;
        en_n = ($urandom_range(0, 99) == 0);
        step();
      end
      en_n = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
